// File: rtl/control_unit_if.sv
// control_unit_if
//
// Bundles the signals exchanged between the control unit and the accumulator
// datapath (DP). Clock and Reset are not part of the bundle.
//
// Signals:
//   IR[2:0]    opcode (IR[7:5] of the instruction register), DP -> control
//   Aeq0       accumulator == 0, DP -> control
//   Apos       accumulator > 0, DP -> control
//   Enter      operator strobe completing an IN instruction
//   IRload     load IR from memory and advance, control -> DP
//   JMPmux     select IR[4:0] as next PC
//   PCload     load PC
//   Meminst    memory address = IR[4:0] (else PC)
//   MemWr      write A to memory
//   Asel[1:0]  A source: 00 add/sub, 01 INPUT, 10 memory data
//   Aload      load A
//   Sub        ALU subtract (else add)
//   Halt       processor halted
//   State[3:0] current state code, for debug and verification
//
// Modports:
//   master  the control unit side (drives control, reads status)
//   slave   the datapath side (drives status, reads control)

interface control_unit_if;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       Enter;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;
    logic       Halt;
    logic [3:0] State;

    modport master (
        input  IR, Aeq0, Apos, Enter,
        output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
        output Halt, State
    );

    modport slave (
        output IR, Aeq0, Apos, Enter,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
        input  Halt, State
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
//
// Fetch / decode / execute sequencer for the 8-bit accumulator datapath.
// One FETCH cycle, one DECODE cycle, then one execute state chosen by the
// opcode. IN waits in its execute state until Enter; HALT is terminal
// until Reset.
//
// Ports:
//   Clock   system clock, rising edge
//   Reset   synchronous, active-high; also blanks all control outputs
//           combinationally while asserted
//   bus     control_unit_if.master (opcode/status in, control words out,
//           Halt, State debug code)
//
// Handshake: IN holds in its state with Asel=01; the cycle in which Enter is
// high loads A (Aload=Enter) and that same edge returns to FETCH, so an
// Enter held high gives exactly one load per IN instruction.

module control_unit (
    input  logic                  Clock,
    input  logic                  Reset,
    control_unit_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_LOAD   = 4'd2,
        S_STORE  = 4'd3,
        S_ADD    = 4'd4,
        S_SUB    = 4'd5,
        S_IN     = 4'd6,
        S_JZ     = 4'd7,
        S_JPOS   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t state_q, state_d;

    logic       irload, jmpmux, pcload, meminst, memwr, aload, sub, halt;
    logic [1:0] asel;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs. Unlisted codes 10..15 fall into the default
    // arm: all outputs low and back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        irload  = 1'b0;
        jmpmux  = 1'b0;
        pcload  = 1'b0;
        meminst = 1'b0;
        memwr   = 1'b0;
        asel    = 2'b00;
        aload   = 1'b0;
        sub     = 1'b0;
        halt    = 1'b0;

        case (state_q)
            S_FETCH: begin
                irload  = 1'b1;
                pcload  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                meminst = 1'b1;
                case (bus.IR)
                    3'b000:  state_d = S_LOAD;
                    3'b001:  state_d = S_STORE;
                    3'b010:  state_d = S_ADD;
                    3'b011:  state_d = S_SUB;
                    3'b100:  state_d = S_IN;
                    3'b101:  state_d = S_JZ;
                    3'b110:  state_d = S_JPOS;
                    default: state_d = S_HALT;
                endcase
            end
            S_LOAD: begin
                meminst = 1'b1;
                asel    = 2'b10;
                aload   = 1'b1;
            end
            S_STORE: begin
                meminst = 1'b1;
                memwr   = 1'b1;
            end
            S_ADD: begin
                meminst = 1'b1;
                aload   = 1'b1;
            end
            S_SUB: begin
                meminst = 1'b1;
                aload   = 1'b1;
                sub     = 1'b1;
            end
            S_IN: begin
                asel    = 2'b01;
                aload   = bus.Enter;
                state_d = bus.Enter ? S_FETCH : S_IN;
            end
            S_JZ: begin
                jmpmux = 1'b1;
                pcload = bus.Aeq0;
            end
            S_JPOS: begin
                jmpmux = 1'b1;
                pcload = bus.Apos;
            end
            S_HALT: begin
                halt    = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset blanks every control line in the same cycle, so nothing is
        // written while the state register is still being forced.
        if (Reset) begin
            irload  = 1'b0;
            jmpmux  = 1'b0;
            pcload  = 1'b0;
            meminst = 1'b0;
            memwr   = 1'b0;
            asel    = 2'b00;
            aload   = 1'b0;
            sub     = 1'b0;
            halt    = 1'b0;
        end
    end

    assign bus.IRload  = irload;
    assign bus.JMPmux  = jmpmux;
    assign bus.PCload  = pcload;
    assign bus.Meminst = meminst;
    assign bus.MemWr   = memwr;
    assign bus.Asel    = asel;
    assign bus.Aload   = aload;
    assign bus.Sub     = sub;
    assign bus.Halt    = halt;
    assign bus.State   = state_q;

endmodule

// File: doc/control_unit.md
# control_unit

Finite-state control unit that drives the 8-bit accumulator datapath (`DP`) through the fetch → decode → execute cycle. It consumes the 3-bit opcode `IR` and the status flags `Aeq0` and `Apos` from `DP`. It produces every datapath control signal: `IRload`, `JMPmux`, `PCload`, `Meminst`, `MemWr`, `Asel`, `Aload` and `Sub`. It sits beside `DP` in the top level, sharing `Clock` and `Reset`, and replaces the hand-sequenced control words currently applied by the datapath bench.

## Interface
- Parameters: none.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `IR`  in  3  opcode from `DP` (IR[7:5]). The encoding is fixed as follows:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB
  - 100 IN, 101 JZ, 110 JPOS, 111 HALT
- `Aeq0`  in  1  accumulator == 0, combinational from `DP`.
- `Apos`  in  1  accumulator > 0 (bit 7 clear and nonzero), combinational from `DP`.
- `Enter`  in  1  operator strobe that completes an IN instruction; synchronous level.
- `IRload`  out  1  load `IR` from memory and advance.
- `JMPmux`  out  1  select `IR[4:0]` as the next PC.
- `PCload`  out  1  load PC.
- `Meminst`  out  1  memory address = `IR[4:0]` (else PC).
- `MemWr`  out  1  write A to memory.
- `Asel`  out  2  A source: 00 = add/sub result, 01 = `INPUT`, 10 = memory data, 11 = unused.
- `Aload`  out  1  load A.
- `Sub`  out  1  ALU subtract (else add).
- `Halt`  out  1  processor halted.
- `State`  out  4  current state code, for debug and verification.

## Operation
- States and codes:
  - FETCH=0, DECODE=1, LOAD=2, STORE=3, ADD=4, SUB=5
  - IN=6, JZ=7, JPOS=8, HALT=9
  - Codes 10–15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE unconditionally.
  - DECODE → the execute state selected by `IR`, sampled at the DECODE edge.
  - LOAD, STORE, ADD, SUB, JZ and JPOS → FETCH.
  - IN → FETCH only when `Enter`=1; otherwise it stays in IN.
  - HALT → HALT, leaving only on `Reset`.
- Moore outputs, with every output 0 unless listed:
  - FETCH: `IRload`=1, `PCload`=1.
  - DECODE: `Meminst`=1.
  - LOAD: `Meminst`=1, `Asel`=10, `Aload`=1.
  - STORE: `Meminst`=1, `MemWr`=1.
  - ADD: `Meminst`=1, `Asel`=00, `Aload`=1, `Sub`=0.
  - SUB: `Meminst`=1, `Asel`=00, `Aload`=1, `Sub`=1.
- Outputs that depend on inputs (Mealy terms):
  - IN: `Asel`=01; `Aload`=`Enter`.
  - JZ: `JMPmux`=1; `PCload`=`Aeq0`.
  - JPOS: `JMPmux`=1; `PCload`=`Apos`.
  - HALT: `Halt`=1.
- Rules:
  - `MemWr` and `Aload` are never both 1.
  - `IRload` is 1 only in FETCH.
  - `MemWr` is 1 only in STORE.

## Timing
- Reset:
  - Any rising edge with `Reset`=1 forces FETCH, regardless of the current state, including IN-wait and HALT.
  - While `Reset`=1, all control outputs and `Halt` are forced to 0 combinationally.
  - `State` reads 0 after the first reset edge.
- The first FETCH outputs appear in the cycle after `Reset` deasserts.
- Latency:
  - Every non-IN instruction takes exactly 3 cycles: FETCH, DECODE, execute.
  - IN takes 3 + N cycles, where N is the number of cycles with `Enter`=0 spent in IN.
- `IR` is sampled only at the DECODE edge. A change of `IR` during execute has no effect on the state sequence.
- `Aeq0` and `Apos` are used combinationally in the JZ/JPOS cycle. They reflect the value of A at the start of that cycle.
- If `Enter` is already 1 on entry to IN, `Aload` pulses in the first IN cycle and the next state is FETCH.
  - `Enter` held high across several instructions causes one load per IN instruction.
- Opcode 111 enters HALT permanently. `Enter`, `Aeq0` and `Apos` are ignored while halted.

## Test plan
- Reset then LOAD:
  - Stimulus: `Reset`=1 for 2 cycles, release, `IR`=000.
  - Required: while `Reset`=1, `State`=0 and all outputs are 0.
  - Then `State` goes 0,1,2,0; `IRload`=`PCload`=1 in cycle 1, `Meminst`=1 in cycle 2, and `Asel`=10 with `Aload`=1 in cycle 3.
- STORE, ADD, SUB:
  - Stimulus: apply opcodes 001, 010, 011 in turn.
  - Required: the execute cycle shows {`Meminst`,`MemWr`}=11, then `Aload`=1 with `Sub`=0 and `Asel`=00, then `Aload`=1 with `Sub`=1; each instruction takes exactly 3 cycles.
- IN handshake:
  - Stimulus: `IR`=100, `Enter` low for 4 cycles then high for 1.
  - Required: `State`=6 for 5 cycles; `Aload`=0 for 4 cycles then 1 for one cycle with `Asel`=01; then `State`=0.
- Conditional jumps:
  - JZ (101) with `Aeq0`=1 gives `JMPmux`=1, `PCload`=1.
  - JZ with `Aeq0`=0 gives `PCload`=0.
  - JPOS (110) with `Apos`=1 gives `PCload`=1; with `Apos`=0 it gives `PCload`=0.
  - All four cases return to FETCH.
- HALT and recovery:
  - Stimulus: `IR`=111 with `Enter` toggling.
  - Required: `State`=9 and `Halt`=1 for 20 or more cycles.
  - Then `Reset` for 1 cycle gives `State`=0 and `Halt`=0.
- Reset mid-IN:
  - Stimulus: in IN with `Enter`=0, assert `Reset` for 1 cycle.
  - Required: the next state is FETCH, no `Aload` pulse occurs, and the normal sequence resumes.
